gcd_unit_param: RTL
===================

Name: gcd_unit_param

Overview:
- Parametrised GCD accelerator; successor to the fixed 16-bit gcd block.
- Uses the same packed req_msg/resp_msg val/rdy handshake style. Operand A sits in the low half of req_msg, operand B in the high half.
- Additions over the fixed block:
  - Configurable width.
  - Selectable algorithm: subtractive Euclid or binary Stein.
  - Request tag passthrough.
  - Iteration count reported with each result.
  - Bounded-iteration timeout with an error flag.
- Used standalone and as the peak-power characterisation target for wider datapaths.

Parameters:
- WIDTH, 16, operand and result width in bits.
- TAG_W, 4, request tag width.
- ALGO, 0, 0 = subtractive Euclid, 1 = binary Stein.
- MAX_CYCLES, 1024, CALC-cycle limit before abort; must be ≥ 2.
- CNT_W, $clog2(MAX_CYCLES+1), width of the cycle counter (derived).

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- reset, input, 1, synchronous, active-high.
- req_msg, input, 2*WIDTH, [WIDTH-1:0] = A, [2*WIDTH-1:WIDTH] = B.
- req_tag, input, TAG_W, opaque tag returned with the result.
- req_val, input, 1, request valid.
- req_rdy, output, 1, request ready.
- resp_msg, output, WIDTH, GCD result.
- resp_tag, output, TAG_W, tag of the originating request.
- resp_cycles, output, CNT_W, number of CALC cycles spent.
- resp_err, output, 1, 1 = aborted on MAX_CYCLES.
- resp_val, output, 1, response valid.
- resp_rdy, input, 1, response ready.

Behaviour:
- Reset: synchronous and active-high, sampled on the rising edge of clk.
  - State goes to IDLE.
  - resp_val=0, resp_msg=0, resp_tag=0, resp_cycles=0, resp_err=0, req_rdy=1 on the cycle after reset is sampled.
  - Reset mid-CALC or mid-DONE drops the operation; no response is issued.
- FSM states: IDLE → CALC → DONE → IDLE.
- IDLE:
  - req_rdy=1.
  - On req_val&&req_rdy: A←req_msg low half, B←req_msg high half, tag←req_tag, cnt←0, K←0, err←0, go to CALC.
- CALC: req_rdy=0, resp_val=0. Each cycle cnt←cnt+1 and exactly one step executes:
  - ALGO=0, by priority:
    1. B==0 → result=A, go to DONE.
    2. A<B → swap A and B.
    3. Otherwise A←A−B.
  - ALGO=1 (Stein), by priority:
    1. A==0 → result=B<<K, go to DONE.
    2. B==0 → result=A<<K, go to DONE.
    3. A and B both even → A>>=1, B>>=1, K++.
    4. A even → A>>=1.
    5. B even → B>>=1.
    6. A≥B → A←A−B.
    7. Otherwise B←B−A.
    - K width is $clog2(WIDTH)+1.
    - The shift back (<<K) is computed in WIDTH bits; it cannot overflow because the result is ≤ max(A,B).
- Timeout: if the cycle about to execute would make cnt==MAX_CYCLES and that step is not terminal, no datapath update occurs. resp_err←1, result←current A, go to DONE.
- DONE:
  - resp_val=1; resp_msg, resp_tag, resp_cycles and resp_err are held stable.
  - On resp_rdy → IDLE.
  - req_rdy=0 in DONE, so there is one bubble cycle minimum between the response handshake and the next request acceptance.
- Latency: resp_val rises the cycle after the terminal CALC cycle.
- Zero operands are legal:
  - gcd(0,0)=0.
  - gcd(0,x)=x.
  - gcd(x,0)=x.
- All arithmetic is unsigned, WIDTH bits, with no wrap (subtraction only when minuend ≥ subtrahend).
- resp_msg/resp_tag/resp_cycles/resp_err retain their last values in IDLE and CALC. They are valid only while resp_val=1.
- req_val while req_rdy=0 is ignored. Upstream must hold req_msg and req_tag until the handshake.

Decomposition:
- Package gcd_pkg:
  - ALGO_EUCLID=0 and ALGO_STEIN=1 constants.
  - FSM state enum: IDLE, CALC, DONE.
  - Width helper functions.
- One sub-module, gcd_step_dp:
  - Combinational single-step datapath, parameterised by WIDTH and ALGO.
  - Inputs: A, B, K.
  - Outputs: next A, next B, next K, done, result.
- The top module holds the FSM, counter, tag register and handshake.

Test Plan:
- ALGO=0, WIDTH=16, A=16, B=8, tag=3 → resp_msg=8, resp_cycles=4, resp_tag=3, resp_err=0.
- ALGO=0, A=15, B=12 → resp_msg=3, resp_cycles=8; with resp_rdy held low for 5 cycles, resp_val and all outputs stay stable until the handshake.
- ALGO=0, zeros:
  - A=0, B=0 → resp_msg=0, cycles=1.
  - A=0, B=5 → resp_msg=5, cycles=2.
- ALGO=0, MAX_CYCLES=16, A=65535, B=1 → resp_err=1, resp_cycles=16, resp_msg=65520.
- ALGO=1, WIDTH=32:
  - A=16, B=8 → resp_msg=8.
  - A=3873906103, B=128000 → resp_msg equals the reference-model gcd.
  - Randomised 1000 pairs match a software gcd.
- Reset asserted on the 3rd CALC cycle of A=15, B=12 → no resp_val; req_rdy=1 the next cycle; a subsequent request A=16, B=8 completes normally.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared constants, FSM state encoding and width helpers for the parametrised GCD unit.
package gcd_pkg;

  localparam int ALGO_EUCLID = 0;
  localparam int ALGO_STEIN  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Stein's power-of-two accumulator must count up to WIDTH-1 shifts.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/gcd_unit_param_if.sv
// Request/response bundle of the GCD unit; master is the requester, slave is the unit.
interface gcd_unit_param_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int CNT_W = 11
);

  // Handshake: a transfer happens on a rising clk edge where val && rdy; the
  // sender keeps its payload stable from raising val until that edge.
  logic [2*WIDTH-1:0] req_msg;
  logic [TAG_W-1:0]   req_tag;
  logic               req_val;
  logic               req_rdy;

  logic [WIDTH-1:0]   resp_msg;
  logic [TAG_W-1:0]   resp_tag;
  logic [CNT_W-1:0]   resp_cycles;
  logic               resp_err;
  logic               resp_val;
  logic               resp_rdy;

  modport master (
    output req_msg, req_tag, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_tag, resp_cycles, resp_err, resp_val
  );

  modport slave (
    input  req_msg, req_tag, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_tag, resp_cycles, resp_err, resp_val
  );

endinterface

// File: rtl/gcd_step_dp.sv
// One combinational GCD iteration: subtractive Euclid or binary Stein, chosen by ALGO.
module gcd_step_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ALGO  = ALGO_EUCLID,
  parameter int K_W   = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [K_W-1:0]   k_nxt,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  generate
    if (ALGO == ALGO_STEIN) begin : g_stein
      always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = '0;
        // The shift back cannot overflow: the result never exceeds max(a,b) << k.
        if (a == '0) begin
          done   = 1'b1;
          result = b << k;
        end else if (b == '0) begin
          done   = 1'b1;
          result = a << k;
        end else if (!a[0] && !b[0]) begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + 1'b1;
        end else if (!a[0]) begin
          a_nxt = a >> 1;
        end else if (!b[0]) begin
          b_nxt = b >> 1;
        end else if (a >= b) begin
          a_nxt = a - b;
        end else begin
          b_nxt = b - a;
        end
      end
    end else begin : g_euclid
      always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = '0;
        if (b == '0) begin
          done   = 1'b1;
          result = a;
        end else if (a < b) begin
          a_nxt = b;
          b_nxt = a;
        end else begin
          a_nxt = a - b;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/gcd_unit_param.sv
// Parametrised GCD accelerator: accepts tagged operand pairs, iterates one step per
// cycle and returns the result with its tag, iteration count and a timeout flag.
module gcd_unit_param
  import gcd_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int TAG_W      = 4,
  parameter int ALGO       = ALGO_EUCLID,
  parameter int MAX_CYCLES = 1024,
  parameter int CNT_W      = cnt_width(MAX_CYCLES)
) (
  input  logic                   clk,
  input  logic                   reset,
  gcd_unit_param_if.slave        io,
  output logic [1:0]             dbg_state
);

  localparam int K_W = k_width(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  generate
    if (MAX_CYCLES < 2) begin : g_bad_max
      $error("gcd_unit_param: MAX_CYCLES must be at least 2");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;

  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [K_W-1:0]   k_nxt;
  logic             step_done;
  logic [WIDTH-1:0] step_result;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_limit;

  gcd_step_dp #(
    .WIDTH (WIDTH),
    .ALGO  (ALGO),
    .K_W   (K_W)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .k_nxt  (k_nxt),
    .done   (step_done),
    .result (step_result)
  );

  // cnt_inc is the count this CALC cycle will report if it ends the operation.
  assign cnt_inc  = cnt_q + 1'b1;
  assign at_limit = (cnt_inc == CNT_W'(MAX_CYCLES));

  assign io.req_rdy  = (state == ST_IDLE);
  assign io.resp_val = (state == ST_DONE);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      k_q            <= '0;
      cnt_q          <= '0;
      tag_q          <= '0;
      io.resp_msg    <= '0;
      io.resp_tag    <= '0;
      io.resp_cycles <= '0;
      io.resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.req_val) begin
            a_q   <= io.req_msg[WIDTH-1:0];
            b_q   <= io.req_msg[2*WIDTH-1:WIDTH];
            tag_q <= io.req_tag;
            cnt_q <= '0;
            k_q   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_inc;
          if (step_done) begin
            io.resp_msg    <= step_result;
            io.resp_tag    <= tag_q;
            io.resp_cycles <= cnt_inc;
            io.resp_err    <= 1'b0;
            state          <= ST_DONE;
          end else if (at_limit) begin
            // Abort without applying the step; report the partial A value.
            io.resp_msg    <= a_q;
            io.resp_tag    <= tag_q;
            io.resp_cycles <= cnt_inc;
            io.resp_err    <= 1'b1;
            state          <= ST_DONE;
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            k_q <= k_nxt;
          end
        end
        ST_DONE: begin
          if (io.resp_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
